data_ram_sync: RTL

- Synchronous, parametrised successor of the combinational data RAM; sits behind the MEM stage of the RISC-V core.
- Byte-addressed, little-endian storage organised as DEPTH words of 4 byte lanes.
- Separate write and read ports: registered 1-cycle read, sign/zero extension, alignment and range checking.
- Self-clearing init state machine zeroes the array after reset.

---
 rtl/data_ram_sync_pkg.sv | 50 +++++
 rtl/data_ram_sync_if.sv | 35 +++
 rtl/data_ram_sync_lane_ext.sv | 32 +++
 rtl/data_ram_sync.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/data_ram_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_sync_pkg
//  Description : Shared size codes, FSM state codes and lane helpers for the
//                synchronous data RAM and the load unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_ram_sync_pkg;

    // Access size codes carried on wsize/rsize
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    // Controller states: clear the array after reset, then serve requests
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    // Byte lanes touched by an access of the given size at the given lane
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << lane;
            SIZE_HALF: m = 4'b0011 << lane;
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    // HALF needs an even address, WORD needs a word-aligned address
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_sync_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_sync_if
//  Description : Read/write bus between the MEM stage and the data RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_ram_sync_if #(
    parameter int ADDR_W = 17
);
    logic              ce;
    logic              ready;
    logic              we;
    logic [1:0]        wsize;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              werr;
    logic              re;
    logic [1:0]        rsize;
    logic              rsigned;
    logic [ADDR_W-1:0] raddr;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              rerr;

    modport master (
        output ce, we, wsize, waddr, wdata, re, rsize, rsigned, raddr,
        input  ready, werr, rdata, rvalid, rerr
    );

    modport slave (
        input  ce, we, wsize, waddr, wdata, re, rsize, rsigned, raddr,
        output ready, werr, rdata, rvalid, rerr
    );
endinterface
`default_nettype wire

// File: rtl/data_ram_sync_lane_ext.sv
`default_nettype none
// ============================================================================
//  Module      : ram_lane_ext
//  Description : Aligns the addressed bytes of a 32-bit word to bit 0 and
//                sign/zero-extends BYTE and HALF results. Shared with the
//                load unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_lane_ext
    import data_ram_sync_pkg::*;
(
    input  wire logic [3:0][7:0] i_bytes,
    input  wire logic [1:0]      i_lane,
    input  wire logic [1:0]      i_size,
    input  wire logic            i_signed,
    output logic [31:0]          o_data
);
    logic [31:0] w_shift;

    assign w_shift = i_bytes >> {i_lane, 3'b000};

    // Select the result width and fill the upper bits
    always_comb begin
        o_data = w_shift;
        case (i_size)
            SIZE_BYTE: o_data = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
            SIZE_HALF: o_data = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
            default:   o_data = w_shift;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/data_ram_sync.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_sync
//  Description : Synchronous byte-addressed little-endian data RAM with
//                separate write and registered read ports, alignment/range
//                checking and a post-reset clearing sequence.
//                Build option DATA_RAM_WR_FWD_EN: write-first on a same-cycle
//                read/write byte collision (default is read-first).
//  Revision    : 1.0 - initial release
// ============================================================================
module data_ram_sync
    import data_ram_sync_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    data_ram_sync_if.slave  bus
);
    localparam int c_WORD_W = ADDR_W - 2;
    localparam int c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DEPTH - 1);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("data_ram_sync: DATA_W must be 32");
    end
    if ((64'(1) << c_WORD_W) < 64'(DEPTH)) begin : g_bad_depth
        $error("data_ram_sync: ADDR_W too small for DEPTH");
    end

    state_e              r_state, w_state_nx;
    logic [c_IDX_W-1:0]  r_idx, w_idx_nx;
    logic [3:0][7:0]     r_mem [DEPTH];
    logic [31:0]         r_rdata;
    logic                r_rvalid, r_rerr, r_werr;

    logic [c_WORD_W-1:0] w_wword, w_rword;
    logic [1:0]          w_wlane, w_rlane;
    logic                w_active, w_wbad, w_rbad;
    logic                w_wr_acc, w_wr_rej, w_rd_acc, w_rd_rej;
    logic [3:0]          w_wmask;
    logic [3:0][7:0]     w_wbytes, w_rarr, w_rbytes;
    logic [31:0]         w_rext;

    assign w_wword = bus.waddr[ADDR_W-1:2];
    assign w_wlane = bus.waddr[1:0];
    assign w_rword = bus.raddr[ADDR_W-1:2];
    assign w_rlane = bus.raddr[1:0];

    // Requests are only considered once the clear sequence is done
    assign w_active = bus.ce & (r_state == ST_IDLE);

    assign w_wbad = (bus.wsize == SIZE_RSVD) | misaligned(bus.wsize, w_wlane)
                  | (32'(w_wword) >= 32'(DEPTH));
    assign w_rbad = (bus.rsize == SIZE_RSVD) | misaligned(bus.rsize, w_rlane)
                  | (32'(w_rword) >= 32'(DEPTH));

    assign w_wr_acc = w_active & bus.we & ~w_wbad;
    assign w_wr_rej = w_active & bus.we &  w_wbad;
    assign w_rd_acc = w_active & bus.re & ~w_rbad;
    assign w_rd_rej = w_active & bus.re &  w_rbad;

    // Right-justified write data moved onto the addressed lanes
    assign w_wmask  = lane_mask(bus.wsize, w_wlane);
    assign w_wbytes = bus.wdata << {w_wlane, 3'b000};

    // Array update: zero one word per cycle during INIT, else masked write
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_idx] <= '0;
        end else if (w_wr_acc) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wmask[k]) begin
                    r_mem[w_wword[c_IDX_W-1:0]][k] <= w_wbytes[k];
                end
            end
        end
    end

    assign w_rarr = r_mem[w_rword[c_IDX_W-1:0]];

    // Read word as seen by this cycle's read, resolving write collisions
    always_comb begin
        w_rbytes = w_rarr;
`ifdef DATA_RAM_WR_FWD_EN
        for (int k = 0; k < 4; k++) begin
            if (w_wr_acc && (w_wword == w_rword) && w_wmask[k]) begin
                w_rbytes[k] = w_wbytes[k];
            end
        end
`endif
    end

    ram_lane_ext u_lane_ext (
        .i_bytes  (w_rbytes),
        .i_lane   (w_rlane),
        .i_size   (bus.rsize),
        .i_signed (bus.rsigned),
        .o_data   (w_rext)
    );

    // Registered read result and error pulses; rdata is zero unless valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
            r_werr   <= 1'b0;
        end else begin
            r_rdata  <= w_rd_acc ? w_rext : 32'h0;
            r_rvalid <= w_rd_acc;
            r_rerr   <= w_rd_rej;
            r_werr   <= w_wr_rej;
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    // Controller next state: walk every word once, then stay idle
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        case (r_state)
            ST_INIT: begin
                if (r_idx == c_LAST) begin
                    w_state_nx = ST_IDLE;
                    w_idx_nx   = '0;
                end else begin
                    w_idx_nx   = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.ready  = (r_state == ST_IDLE);
    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.rerr   = r_rerr;
    assign bus.werr   = r_werr;
endmodule
`default_nettype wire
